// File: rtl/letc_mtimer.sv
// letc_mtimer: 64-bit machine timer (mtime/mtimecmp) behind a single-outstanding register bus.
// Optional prescaler is built when LETC_MTIMER_PRESCALER_EN is defined.
module letc_mtimer #(
  parameter bit          RESET_ENABLE = 1'b1,
  parameter int unsigned PRESCALE_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [4:0]  i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_timer_irq_pending
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam logic [4:0] ADDR_MTIMEL    = 5'h00;
  localparam logic [4:0] ADDR_MTIMEH    = 5'h04;
  localparam logic [4:0] ADDR_MTIMECMPL = 5'h08;
  localparam logic [4:0] ADDR_MTIMECMPH = 5'h0C;
  localparam logic [4:0] ADDR_CTRL      = 5'h10;
  localparam logic [4:0] ADDR_SHADOWH   = 5'h14;
`ifdef LETC_MTIMER_PRESCALER_EN
  localparam logic [4:0] ADDR_PRESCALE  = 5'h18;
`endif

  if (PRESCALE_W < 1 || PRESCALE_W > 32) begin : g_prescale_w_check
    $error("letc_mtimer: PRESCALE_W must be in 1..32");
  end

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  state_e      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        irq_q;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rdata_d;
  logic        err_d;
  logic        accept_s;
  logic        tick_s;

`ifdef LETC_MTIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  assign tick_s = (pcnt_q == prescale_q);
`else
  assign tick_s = 1'b1;
`endif

  assign accept_s = i_req_valid & req_ready_q & (state_q == ST_IDLE);

  // Next-state of the timer registers and the response for an accepted access.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    shadow_d   = shadow_q;
    rdata_d    = 32'd0;
    err_d      = 1'b0;
    if (en_q && tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
`ifdef LETC_MTIMER_PRESCALER_EN
    prescale_d = prescale_q;
    if (en_q) begin
      pcnt_d = tick_s ? '0 : pcnt_q + PRESCALE_W'(1);
    end else begin
      pcnt_d = pcnt_q;
    end
`endif
    if (!accept_s) begin
      rdata_d = 32'd0;
    end else if (i_req_addr[1:0] != 2'b00) begin
      err_d = 1'b1;
    end else begin
      // Software writes to mtime override the increment; the other half holds.
      case (i_req_addr)
        ADDR_MTIMEL: begin
          if (i_req_wen) begin
            mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_req_wdata, i_req_wstrb)};
          end else begin
            rdata_d  = mtime_q[31:0];
            shadow_d = mtime_q[63:32];
          end
        end
        ADDR_MTIMEH: begin
          if (i_req_wen) begin
            mtime_d = {merge_bytes(mtime_q[63:32], i_req_wdata, i_req_wstrb), mtime_q[31:0]};
          end else begin
            rdata_d = mtime_q[63:32];
          end
        end
        ADDR_MTIMECMPL: begin
          if (i_req_wen) begin
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], i_req_wdata, i_req_wstrb);
          end else begin
            rdata_d = mtimecmp_q[31:0];
          end
        end
        ADDR_MTIMECMPH: begin
          if (i_req_wen) begin
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], i_req_wdata, i_req_wstrb);
          end else begin
            rdata_d = mtimecmp_q[63:32];
          end
        end
        ADDR_CTRL: begin
          if (i_req_wen) begin
            en_d = i_req_wstrb[0] ? i_req_wdata[0] : en_q;
          end else begin
            rdata_d = {31'd0, en_q};
          end
        end
        ADDR_SHADOWH: begin
          if (i_req_wen) begin
            err_d = 1'b1;
          end else begin
            rdata_d = shadow_q;
          end
        end
`ifdef LETC_MTIMER_PRESCALER_EN
        ADDR_PRESCALE: begin
          if (i_req_wen) begin
            prescale_d = PRESCALE_W'(merge_bytes(32'(prescale_q), i_req_wdata, i_req_wstrb));
            pcnt_d     = '0;
          end else begin
            rdata_d = 32'(prescale_q);
          end
        end
`endif
        default: begin
          err_d = 1'b1;
        end
      endcase
      if (err_d) begin
        rdata_d = 32'd0;
      end else begin
        rdata_d = rdata_d;
      end
    end
  end

  // Timer state registers and the registered compare interrupt.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q       <= RESET_ENABLE;
      shadow_q   <= 32'd0;
      irq_q      <= 1'b0;
`ifdef LETC_MTIMER_PRESCALER_EN
      prescale_q <= '0;
      pcnt_q     <= '0;
`endif
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      shadow_q   <= shadow_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
`ifdef LETC_MTIMER_PRESCALER_EN
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
`endif
    end
  end

  // Bus handshake FSM with registered ready and response fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q     <= ST_RESP;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
          end else begin
            req_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready         = req_ready_q;
  assign o_rsp_valid         = rsp_valid_q;
  assign o_rsp_rdata         = rsp_rdata_q;
  assign o_rsp_err           = rsp_err_q;
  assign o_timer_irq_pending = irq_q;

endmodule

// File: tb/tb_letc_mtimer.sv
// Directed self-checking bench for letc_mtimer; expected values are hand-derived cycle counts.
module tb_letc_mtimer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        timer_irq;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] rdata_v, rdata_a;
  logic        err_v, irq_v;

  always #5 clk = ~clk;

  letc_mtimer dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_req_valid         (req_valid),
    .o_req_ready         (req_ready),
    .i_req_wen           (req_wen),
    .i_req_addr          (req_addr),
    .i_req_wdata         (req_wdata),
    .i_req_wstrb         (req_wstrb),
    .o_rsp_valid         (rsp_valid),
    .i_rsp_ready         (rsp_ready),
    .o_rsp_rdata         (rsp_rdata),
    .o_rsp_err           (rsp_err),
    .o_timer_irq_pending (timer_irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic bus_xfer(input logic wen, input logic [4:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata,
                          output logic err, output logic irq);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("req_ready_timeout", 64'(n), 64'd0);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    @(negedge clk);
    req_valid = 1'b0;
    req_wen   = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rsp_valid_timeout", 64'(n), 64'd0);
    rdata = rsp_rdata;
    err   = rsp_err;
    irq   = timer_irq;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    logic        e, q;
    bus_xfer(1'b1, addr, wdata, 4'hF, d, e, q);
    check("wr_err", 64'(e), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 5'h00;
    req_wdata = 32'd0;
    req_wstrb = 4'h0;
    rsp_ready = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    check("rst_irq",       64'(timer_irq), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Free-running count after reset: 10 edges before the read is accepted
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("ready_after_rst", 64'(req_ready), 64'd1);
      check("irq_idle", 64'(timer_irq), 64'd0);
    end
    bus_xfer(1'b0, 5'h00, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("mtimel_after_10", 64'(rdata_v), 64'd10);
    check("mtimel_err", 64'(err_v), 64'd0);

    // Compare match at 100
    wr(5'h0C, 32'd0);
    wr(5'h08, 32'd100);
    wr(5'h10, 32'd0);
    wr(5'h00, 32'd95);
    wr(5'h04, 32'd0);
    wr(5'h10, 32'd1);
    check("irq_mtime96", 64'(timer_irq), 64'd0);
    for (int i = 97; i <= 100; i++) begin
      @(negedge clk);
      check("irq_before_match", 64'(timer_irq), 64'd0);
    end
    @(negedge clk);
    check("irq_rise", 64'(timer_irq), 64'd1);
    bus_xfer(1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF, rdata_v, err_v, irq_v);
    check("irq_held_at_cmp_write", 64'(irq_v), 64'd1);
    check("irq_drop", 64'(timer_irq), 64'd0);
    wr(5'h0C, 32'hFFFF_FFFF);
    check("irq_low_after_cmph", 64'(timer_irq), 64'd0);

    // Wrap of mtime and MTIMEL/SHADOWH pair
    wr(5'h10, 32'd0);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    bus_xfer(1'b1, 5'h10, 32'd1, 4'hF, rdata_v, err_v, irq_v);
    check("irq_at_all_ones", 64'(irq_v), 64'd1);
    check("irq_wrap_edge", 64'(timer_irq), 64'd1);
    @(negedge clk);
    check("irq_after_wrap", 64'(timer_irq), 64'd0);
    bus_xfer(1'b0, 5'h00, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("wrap_mtimel", 64'(rdata_v), 64'd1);
    bus_xfer(1'b0, 5'h14, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("wrap_shadowh", 64'(rdata_v), 64'd0);
    check("wrap_shadowh_err", 64'(err_v), 64'd0);

    // Response back-pressure
    wr(5'h08, 32'h1234_5678);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 5'h08;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("released_rsp_valid", 64'(rsp_valid), 64'd0);
    check("released_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = 5'h10;
    @(negedge clk);
    req_valid = 1'b0;
    check("accept_next_cycle", 64'(rsp_valid), 64'd1);
    check("accept_next_rdata", 64'(rsp_rdata), 64'd1);
    @(negedge clk);

    // Errors, no-op write, byte merge, freeze
    bus_xfer(1'b0, 5'h02, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("misaligned_err", 64'(err_v), 64'd1);
    check("misaligned_rdata", 64'(rdata_v), 64'd0);
    bus_xfer(1'b1, 5'h14, 32'hDEAD_BEEF, 4'hF, rdata_v, err_v, irq_v);
    check("shadow_write_err", 64'(err_v), 64'd1);
    bus_xfer(1'b0, 5'h14, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("shadow_unchanged", 64'(rdata_v), 64'd0);
    bus_xfer(1'b1, 5'h10, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("noop_write_err", 64'(err_v), 64'd0);
    bus_xfer(1'b0, 5'h10, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("noop_en_kept", 64'(rdata_v), 64'd1);
    bus_xfer(1'b0, 5'h1C, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("unmapped_err", 64'(err_v), 64'd1);
    bus_xfer(1'b1, 5'h08, 32'h0000_AB00, 4'b0010, rdata_v, err_v, irq_v);
    bus_xfer(1'b0, 5'h08, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("byte_merge", 64'(rdata_v), 64'h1234_AB78);
    wr(5'h10, 32'd0);
    bus_xfer(1'b0, 5'h00, 32'd0, 4'h0, rdata_a, err_v, irq_v);
    bus_xfer(1'b0, 5'h00, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("freeze", 64'(rdata_v), 64'(rdata_a));
    wr(5'h10, 32'd1);

`ifdef LETC_MTIMER_PRESCALER_EN
    // Prescale 3: reads spaced exactly 20 edges apart differ by 5
    wr(5'h18, 32'd3);
    bus_xfer(1'b0, 5'h18, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("prescale_readback", 64'(rdata_v), 64'd3);
    bus_xfer(1'b0, 5'h00, 32'd0, 4'h0, rdata_a, err_v, irq_v);
    repeat (18) @(negedge clk);
    bus_xfer(1'b0, 5'h00, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("prescale_delta", 64'(rdata_v - rdata_a), 64'd5);
`else
    bus_xfer(1'b0, 5'h18, 32'd0, 4'h0, rdata_v, err_v, irq_v);
    check("prescale_rd_err", 64'(err_v), 64'd1);
    bus_xfer(1'b1, 5'h18, 32'd3, 4'hF, rdata_v, err_v, irq_v);
    check("prescale_wr_err", 64'(err_v), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/letc_mtimer.md
Name: letc_mtimer

Overview:
- Machine-timer peripheral that generates `i_timer_irq_pending` for the LETC Core.
- Holds a 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register.
- Software accesses both over a simple single-outstanding request/response register bus, bridged from the core's memory-mapped IO.
- The timer interrupt is level-sensitive and registered.

Parameters:
- RESET_ENABLE, 1, reset value of CTRL.EN; 1 means counting starts out of reset.
- PRESCALE_W, 16, width of the PRESCALE register and its tick counter. Used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid & ready.
- i_req_wen  in  1  1 = write, 0 = read.
- i_req_addr  in  5  byte address.
- i_req_wdata  in  32  write data.
- i_req_wstrb  in  4  byte enables for writes.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumed when valid & ready.
- o_rsp_rdata  out  32  read data; 0 for writes and errors.
- o_rsp_err  out  1  access error.
- o_timer_irq_pending  out  1  level interrupt to the core.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; CTRL.EN = RESET_ENABLE; shadow_hi = 0.
  - Outputs: o_req_ready = 0 while reset is asserted, then 1 in the first cycle after release. o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0, o_timer_irq_pending = 0.
- Register map (word-aligned):
  - 0x00 MTIMEL: mtime[31:0]. A read also captures mtime[63:32] into shadow_hi.
  - 0x04 MTIMEH: live mtime[63:32].
  - 0x08 MTIMECMPL.
  - 0x0C MTIMECMPH.
  - 0x10 CTRL: bit0 EN; other bits read 0 and ignore writes.
  - 0x14 SHADOWH: read-only shadow_hi; writes error.
  - 0x18 PRESCALE: see optional feature.
- Errors: i_req_addr[1:0] != 0 or an unmapped address -> o_rsp_err = 1, no state change.
- Write merging: writes are byte-merged with i_req_wstrb. wstrb = 0 is a legal no-op write.
- Bus FSM, two states:
  - IDLE: o_req_ready = 1. On valid & ready, perform the access (register update at this edge) and go to RESP. Load rdata and err, set o_rsp_valid = 1.
  - RESP: o_req_ready = 0; response fields held stable. When i_rsp_ready = 1, clear o_rsp_valid and return to IDLE.
  - Latency: response visible the cycle after accept. Maximum throughput is one access every 2 cycles.
- Counter:
  - When EN = 1 and tick = 1, mtime <= mtime + 1 (modulo 2^64). 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - Without the optional feature, tick = 1 every cycle.
- Simultaneous software write and increment to mtime: the written half takes the written value, and the other half holds (no carry from the increment that cycle). The write has priority.
- Interrupt:
  - o_timer_irq_pending <= (mtime >= mtimecmp), unsigned 64-bit comparison of the current register values.
  - One-cycle latency after either register changes.
  - Stays asserted until mtimecmp is raised or mtime wraps.
  - EN = 0 freezes mtime but still updates the compare.
- Reset mid-transaction: an in-flight response is dropped and all state returns to reset values immediately.

Optional Feature:
- Macro: LETC_MTIMER_PRESCALER_EN.
- Defined:
  - PRESCALE register (PRESCALE_W bits, reset 0) and a tick counter pcnt (reset 0) are present.
  - tick = (pcnt == PRESCALE). When EN = 1, pcnt <= tick ? 0 : pcnt + 1.
  - The counter increments once every PRESCALE+1 cycles.
  - Writing PRESCALE also clears pcnt. Upper bits read 0.
- Undefined: no prescaler logic; tick = 1 every cycle; address 0x18 returns o_rsp_err = 1.

Test Plan:
- Reset release, RESET_ENABLE = 1, no accesses: after 10 cycles, read MTIMEL -> rdata ≥ 10, err = 0. o_timer_irq_pending stays 0 throughout.
- Write MTIMECMPH = 0, MTIMECMPL = 100, then write CTRL = 0, MTIMEL = 95, MTIMEH = 0, CTRL = 1: irq rises exactly 1 cycle after mtime reaches 100. Writing MTIMECMPL = 0xFFFF_FFFF and MTIMECMPH = 0xFFFF_FFFF drops irq 1 cycle later.
- Write MTIMEL = 0xFFFF_FFFF, MTIMEH = 0xFFFF_FFFF with EN = 1: mtime wraps to 0. The next MTIMEL read then SHADOWH read returns a consistent pair with SHADOWH = 0.
- Hold i_rsp_ready = 0 for 5 cycles after a read: o_rsp_valid and o_rsp_rdata stay stable and o_req_ready = 0. Then i_rsp_ready = 1 -> IDLE, and a new request is accepted next cycle.
- Error and no-op cases:
  - Read addr 0x02 -> err = 1, rdata = 0.
  - Write 0x14 -> err = 1, no state change.
  - Write CTRL with wstrb = 4'b0000 -> err = 0, EN unchanged.
- With LETC_MTIMER_PRESCALER_EN, PRESCALE = 3: mtime advances by 1 every 4 cycles (20 cycles -> +5).
- Without LETC_MTIMER_PRESCALER_EN: access to 0x18 -> err = 1.
